// File: rtl/axil_pkg.sv
// ----------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite register-file slave:
//   RESP_OKAY / RESP_SLVERR : AXI response encodings
//   addr_lsb()              : number of byte-offset address bits for a data width
// ----------------------------------------------------------------------------
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-offset bits inside one data word, e.g. 32-bit data -> 2.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axil_strb_merge.sv
// ----------------------------------------------------------------------------
// axil_strb_merge
// Combinational byte-lane merge: every lane whose strobe bit is set takes the
// new byte, every other lane keeps the old byte.
// Ports:
//   old_data    in  DATA_WIDTH    current register contents
//   new_data    in  DATA_WIDTH    incoming write data
//   strb        in  DATA_WIDTH/8  byte-lane enables
//   merged_data out DATA_WIDTH    resulting register value
// ----------------------------------------------------------------------------
module axil_strb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_data,
    input  logic [DATA_WIDTH-1:0]   new_data,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged_data
);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_lane
            assign merged_data[gi*8 +: 8] = strb[gi] ? new_data[gi*8 +: 8]
                                                     : old_data[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/axil_regfile_slave.sv
// ----------------------------------------------------------------------------
// axil_regfile_slave
// AXI4-Lite slave exposing NUM_REGS registers of DATA_WIDTH bits.
// AW and W are captured independently into one-entry holding registers and
// the write commits on the edge where both are available. Reads have one
// cycle latency and run fully independently of writes.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*                 AXI4-Lite write address/data/response
//   s_ar*/s_r*                      AXI4-Lite read address/data
//   regs_flat                       live register contents, reg i at
//                                   [i*DATA_WIDTH +: DATA_WIDTH]
// ----------------------------------------------------------------------------
module axil_regfile_slave
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int STRB_W   = DATA_WIDTH / 8;

    // Write-side holding state
    logic                  aw_hold_reg;
    logic [IDX_W-1:0]      aw_idx_reg;
    logic                  w_hold_reg;
    logic [DATA_WIDTH-1:0] w_data_reg;
    logic [STRB_W-1:0]     w_strb_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;

    // Read-side state
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;

    logic                  aw_fire;
    logic                  w_fire;
    logic                  ar_fire;
    logic                  commit;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  wr_in_range;
    logic [IDX_W-1:0]      ar_idx;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_value;

    assign s_awready = !aw_hold_reg && !bvalid_reg;
    assign s_wready  = !w_hold_reg && !bvalid_reg;
    assign s_arready = !rvalid_reg;

    assign s_bvalid = bvalid_reg;
    assign s_bresp  = bresp_reg;
    assign s_rvalid = rvalid_reg;
    assign s_rdata  = rdata_reg;
    assign s_rresp  = rresp_reg;

    assign aw_fire = s_awvalid && s_awready;
    assign w_fire  = s_wvalid && s_wready;
    assign ar_fire = s_arvalid && s_arready;

    // A channel counts as available if it is already held or handshakes on
    // this edge; the held copy takes priority because the ready is low then.
    assign commit  = (aw_hold_reg || aw_fire) && (w_hold_reg || w_fire);
    assign wr_idx  = aw_hold_reg ? aw_idx_reg : s_awaddr[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_data = w_hold_reg ? w_data_reg : s_wdata;
    assign wr_strb = w_hold_reg ? w_strb_reg : s_wstrb;
    assign ar_idx  = s_araddr[ADDR_WIDTH-1:ADDR_LSB];

    assign wr_in_range = (32'(wr_idx) < NUM_REGS);
    assign rd_in_range = (32'(ar_idx) < NUM_REGS);

    // Byte-offset address bits carry no meaning for a word register file.
    generate
        if (ADDR_LSB > 0) begin : g_low_addr
            logic unused_low_addr;
            assign unused_low_addr = ^{s_awaddr[ADDR_LSB-1:0], s_araddr[ADDR_LSB-1:0]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Register storage: each register owns its merge and write enable, so
    // an out-of-range index simply matches no register.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] value_reg;
            logic [DATA_WIDTH-1:0] value_next;
            logic                  wr_en;

            axil_strb_merge #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_merge (
                .old_data    (value_reg),
                .new_data    (wr_data),
                .strb        (wr_strb),
                .merged_data (value_next)
            );

            assign wr_en = commit && (wr_idx == IDX_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    value_reg <= '0;
                end else if (wr_en) begin
                    value_reg <= value_next;
                end
            end

            assign regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = value_reg;
        end
    endgenerate

    // Read mux sees the pre-edge register contents, so a read racing a
    // commit to the same register returns the old value.
    always_comb begin
        rd_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_value = regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Write address/data holding and write response
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_hold_reg <= 1'b0;
            aw_idx_reg  <= '0;
            w_hold_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_hold_reg <= 1'b0;
                w_hold_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_fire) begin
                    aw_hold_reg <= 1'b1;
                    aw_idx_reg  <= s_awaddr[ADDR_WIDTH-1:ADDR_LSB];
                end
                if (w_fire) begin
                    w_hold_reg <= 1'b1;
                    w_data_reg <= s_wdata;
                    w_strb_reg <= s_wstrb;
                end
                if (bvalid_reg && s_bready) begin
                    bvalid_reg <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else if (ar_fire) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_in_range ? rd_value : '0;
            rresp_reg  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_reg && s_rready) begin
            rvalid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// ----------------------------------------------------------------------------
// tb_axil_regfile_slave
// Directed scenarios plus randomized write/read traffic for
// axil_regfile_slave, checked against a byte-array model of the register file.
// ----------------------------------------------------------------------------
module tb_axil_regfile_slave;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 4;

    logic              clk;
    logic              rst_n;
    logic [AW-1:0]     s_awaddr;
    logic              s_awvalid;
    logic              s_awready;
    logic [DW-1:0]     s_wdata;
    logic [DW/8-1:0]   s_wstrb;
    logic              s_wvalid;
    logic              s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid;
    logic              s_bready;
    logic [AW-1:0]     s_araddr;
    logic              s_arvalid;
    logic              s_arready;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid;
    logic              s_rready;
    logic [NR*DW-1:0]  regs_flat;

    axil_regfile_slave dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .regs_flat (regs_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: register file as bytes
    logic [7:0] mem [NR][4];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        f = '0;
        for (int i = 0; i < NR; i++)
            for (int b = 0; b < 4; b++)
                f[i*32 + b*8 +: 8] = mem[i][b];
        return f;
    endfunction

    function automatic logic [31:0] model_word(input int idx);
        logic [31:0] w;
        w = '0;
        if (idx < NR)
            for (int b = 0; b < 4; b++)
                w[b*8 +: 8] = mem[idx][b];
        return w;
    endfunction

    task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
        if (idx < NR)
            for (int b = 0; b < 4; b++)
                if (strb[b]) mem[idx][b] = data[b*8 +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++)
            for (int b = 0; b < 4; b++)
                mem[i][b] = 8'h00;
    endtask

    // w_lead > 0: W offered w_lead cycles before AW; < 0: AW leads.
    task automatic write_txn(input logic [AW-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input int bready_delay);
        int aw_start;
        int w_start;
        int cyc;
        int idx;
        bit aw_done;
        bit w_done;
        bit hs_aw;
        bit hs_w;
        logic [1:0] exp_resp;
        logic [NR*DW-1:0] before_flat;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        idx      = int'(addr[AW-1:2]);
        exp_resp = (idx < NR) ? 2'b00 : 2'b10;
        before_flat = model_flat();
        aw_done = 0;
        w_done  = 0;
        cyc     = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge clk);
            if (cyc > 0) begin
                check_eq("pre_commit_bvalid", s_bvalid, 1'b0);
                check_eq("pre_commit_regs", regs_flat, before_flat);
            end
            s_awvalid = !aw_done && (cyc >= aw_start);
            s_awaddr  = addr;
            s_wvalid  = !w_done && (cyc >= w_start);
            s_wdata   = data;
            s_wstrb   = strb;
            hs_aw = s_awvalid && s_awready;
            hs_w  = s_wvalid && s_wready;
            @(posedge clk);
            aw_done = aw_done || hs_aw;
            w_done  = w_done || hs_w;
            cyc++;
        end
        @(negedge clk);
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            check_eq("write_timeout", 1'b0, 1'b1);
            return;
        end
        model_write(idx, data, strb);
        check_eq("bvalid", s_bvalid, 1'b1);
        check_eq("bresp", s_bresp, exp_resp);
        check_eq("regs_after_commit", regs_flat, model_flat());
        for (int k = 0; k < bready_delay; k++) begin
            s_bready = 1'b0;
            @(negedge clk);
            check_eq("bvalid_hold", s_bvalid, 1'b1);
            check_eq("bresp_hold", s_bresp, exp_resp);
            check_eq("awready_blocked", s_awready, 1'b0);
            check_eq("wready_blocked", s_wready, 1'b0);
        end
        s_bready = 1'b1;
        @(negedge clk);
        check_eq("bvalid_clear", s_bvalid, 1'b0);
        s_bready = 1'b0;
        $display("write addr=%0h data=%08h strb=%0h lead=%0d -> resp=%0d", addr, data, strb, w_lead, exp_resp);
    endtask

    task automatic read_txn(input logic [AW-1:0] addr, input int rready_delay);
        int idx;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        idx      = int'(addr[AW-1:2]);
        exp_data = model_word(idx);
        exp_resp = (idx < NR) ? 2'b00 : 2'b10;
        @(negedge clk);
        check_eq("arready", s_arready, 1'b1);
        s_arvalid = 1'b1;
        s_araddr  = addr;
        @(negedge clk);
        s_arvalid = 1'b0;
        check_eq("rvalid", s_rvalid, 1'b1);
        check_eq("rdata", s_rdata, exp_data);
        check_eq("rresp", s_rresp, exp_resp);
        for (int k = 0; k < rready_delay; k++) begin
            s_rready = 1'b0;
            @(negedge clk);
            check_eq("rvalid_hold", s_rvalid, 1'b1);
            check_eq("rdata_hold", s_rdata, exp_data);
            check_eq("arready_blocked", s_arready, 1'b0);
        end
        s_rready = 1'b1;
        @(negedge clk);
        check_eq("rvalid_clear", s_rvalid, 1'b0);
        s_rready = 1'b0;
        $display("read  addr=%0h -> data=%08h resp=%0d", addr, exp_data, exp_resp);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [31:0]   rd;
        logic [3:0]    rs;
        logic [31:0]   old_val;

        rst_n     = 1'b0;
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_eq("reset_regs", regs_flat, '0);
        check_eq("reset_bvalid", s_bvalid, 1'b0);
        check_eq("reset_rvalid", s_rvalid, 1'b0);
        rst_n = 1'b1;
        #1;
        check_eq("post_reset_awready", s_awready, 1'b1);
        check_eq("post_reset_wready", s_wready, 1'b1);
        check_eq("post_reset_arready", s_arready, 1'b1);

        // Same-cycle AW/W, then read back
        write_txn(5'h04, 32'hDEADBEEF, 4'hF, 0, 0);
        read_txn(5'h04, 0);

        // W two cycles ahead of AW with a single-lane strobe
        write_txn(5'h08, 32'h11223344, 4'hF, 0, 0);
        write_txn(5'h08, 32'h000000AA, 4'h1, 2, 0);
        read_txn(5'h08, 0);
        check_eq("reg2_partial", regs_flat[2*DW +: DW], 32'h112233AA);

        // Out-of-range write and read
        write_txn(5'h10, 32'hCAFEF00D, 4'hF, 0, 0);
        read_txn(5'h14, 1);

        // Zero strobe: OKAY, no change
        write_txn(5'h04, 32'h12345678, 4'h0, -1, 0);

        // Response back-pressure
        write_txn(5'h00, 32'hA5A5A5A5, 4'hF, 0, 5);

        // Read racing a commit to the same register sees the old value
        @(negedge clk);
        old_val   = model_word(3);
        check_eq("collide_ready", {s_awready, s_wready, s_arready}, 3'b111);
        s_awvalid = 1'b1;
        s_awaddr  = 5'h0C;
        s_wvalid  = 1'b1;
        s_wdata   = 32'h00000055;
        s_wstrb   = 4'hF;
        s_arvalid = 1'b1;
        s_araddr  = 5'h0C;
        @(negedge clk);
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
        model_write(3, 32'h00000055, 4'hF);
        check_eq("collide_rvalid", s_rvalid, 1'b1);
        check_eq("collide_rdata_old", s_rdata, old_val);
        check_eq("collide_bvalid", s_bvalid, 1'b1);
        check_eq("collide_regs", regs_flat, model_flat());
        s_bready = 1'b1;
        s_rready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        s_rready = 1'b0;
        $display("collide addr=0c old=%08h new=00000055", old_val);
        read_txn(5'h0C, 0);

        // Reset with AW held and a read response pending
        @(negedge clk);
        s_arvalid = 1'b1;
        s_araddr  = 5'h04;
        s_awvalid = 1'b1;
        s_awaddr  = 5'h00;
        @(negedge clk);
        s_arvalid = 1'b0;
        s_awvalid = 1'b0;
        check_eq("aw_held_awready", s_awready, 1'b0);
        check_eq("pending_rvalid", s_rvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_eq("async_reset_bvalid", s_bvalid, 1'b0);
        check_eq("async_reset_rvalid", s_rvalid, 1'b0);
        check_eq("async_reset_rdata", s_rdata, '0);
        check_eq("async_reset_bresp", s_bresp, 2'b00);
        check_eq("async_reset_rresp", s_rresp, 2'b00);
        check_eq("async_reset_regs", regs_flat, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_release_ready", {s_awready, s_wready, s_arready}, 3'b111);
        @(negedge clk);
        s_wvalid = 1'b1;
        s_wdata  = 32'h87654321;
        s_wstrb  = 4'hF;
        @(negedge clk);
        s_wvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("w_alone_no_bvalid", s_bvalid, 1'b0);
            check_eq("w_alone_regs", regs_flat, '0);
            @(negedge clk);
        end
        $display("reset mid-transaction: aw_hold discarded");
        pulse_reset();

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            ra = {3'($urandom_range(0, 7)), 2'($urandom)};
            rd = $urandom;
            rs = 4'($urandom_range(0, 15));
            write_txn(ra, rd, rs, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
            ra = {3'($urandom_range(0, 7)), 2'($urandom)};
            read_txn(ra, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axil_regfile_slave.md
AXIL_REGFILE_SLAVE -- requirements
Module: axil_regfile_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, byte-address width of AW/AR channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values 8, 16, 32, 64.
REQ-003 SHALL have parameter NUM_REGS, default 4, number of registers; legal range 1 to 2^(ADDR_WIDTH-ADDR_LSB), where ADDR_LSB = log2(DATA_WIDTH/8).
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_awaddr  in  ADDR_WIDTH  write address.
- s_awvalid  in  1 / s_awready  out  1  AW handshake.
- s_wdata  in  DATA_WIDTH  write data.
- s_wstrb  in  DATA_WIDTH/8  byte-lane enables.
- s_wvalid  in  1 / s_wready  out  1  W handshake.
- s_bresp  out  2 / s_bvalid  out  1 / s_bready  in  1  write response.
- s_araddr  in  ADDR_WIDTH  read address.
- s_arvalid  in  1 / s_arready  out  1  AR handshake.
- s_rdata  out  DATA_WIDTH / s_rresp  out  2 / s_rvalid  out  1 / s_rready  in  1  read response.
- regs_flat  out  NUM_REGS*DATA_WIDTH  live register contents; register i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-005 SHALL decode register index = addr[ADDR_WIDTH-1:ADDR_LSB]; bits below ADDR_LSB ignored.
REQ-006 SHALL accept AW and W independently, in either order, each held in a one-entry holding register (aw_hold, w_hold flags).
REQ-007 SHALL drive s_awready = !aw_hold && !s_bvalid and s_wready = !w_hold && !s_bvalid, both combinational from registered state.
REQ-008 SHALL commit the write on the clock edge where AW and W are both available (held or handshaking that edge); both flags clear and s_bvalid sets on that same edge.
REQ-009 SHALL update only byte lanes with s_wstrb bit set; wstrb all-zero yields s_bresp OKAY and no change.
REQ-010 SHALL, for index >= NUM_REGS, perform no write and return s_bresp = SLVERR (2'b10); otherwise OKAY (2'b00).
REQ-011 SHALL hold s_bvalid and s_bresp stable until s_bvalid && s_bready, then clear s_bvalid; no new AW/W accepted while s_bvalid is high.
REQ-012 SHALL drive s_arready = !s_rvalid; on AR handshake, register s_rdata/s_rresp and set s_rvalid on the same edge (one-cycle latency).
REQ-013 SHALL return s_rdata = 0 and s_rresp = SLVERR for index >= NUM_REGS.
REQ-014 SHALL hold s_rdata/s_rresp/s_rvalid stable until s_rvalid && s_rready.
REQ-015 SHALL, when a read handshake and a write commit to the same register occur on the same edge, return the pre-write value.
REQ-016 SHALL run read and write channels concurrently with no mutual stall.
REQ-017 SHALL update regs_flat on the commit edge.

Reset
REQ-018 SHALL, on rst_n low, immediately clear all registers to 0, aw_hold, w_hold, s_bvalid, s_rvalid to 0, and s_bresp, s_rresp, s_rdata to 0.
REQ-019 SHALL discard any half-captured write or pending response on reset mid-transaction; no partial register update.
REQ-020 SHALL produce s_awready = s_wready = s_arready = 1 on the first cycle after rst_n deasserts.

Structure
REQ-021 SHALL place RESP_OKAY, RESP_SLVERR, and the ADDR_LSB derivation function in shared package axil_pkg.
REQ-022 SHALL implement byte-lane merge (old data, new data, strobe) as sub-module axil_strb_merge, parametrised by DATA_WIDTH.

Verification
REQ-023 Bench SHALL use default parameters and cover:
- AW 0x04 and W 0xDEADBEEF, strb 0xF same cycle -> bvalid next cycle, bresp 0; read 0x04 -> rdata 0xDEADBEEF, rresp 0 one cycle after AR.
- W 0x000000AA strb 0x1 two cycles before AW 0x08 (reg2 = 0x11223344) -> reg2 = 0x112233AA; commit on AW edge.
- Write 0x10 -> bresp 2'b10, regs_flat unchanged; read 0x14 -> rdata 0, rresp 2'b10.
- bready held low 5 cycles -> bvalid, bresp stable; awready/wready low throughout.
- AR 0x0C coincident with write commit 0x55 to 0x0C (old 0x0) -> rdata 0x0; next read -> 0x55.
- rst_n low while aw_hold set -> all outputs 0; subsequent W alone produces no bvalid.
